// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU operand-feeder slice: default widths and
// the feeder FSM state type.
package tpu_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 16;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_PE_LAT     = 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/pe_feeder_if.sv
// Operand-pair write channel into the PE feeder (valid/ready handshake).
interface pe_feeder_if #(
  parameter int DATA_WIDTH = tpu_pkg::DEF_DATA_WIDTH
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_a;
  logic [DATA_WIDTH-1:0] wr_b;

  modport master (output wr_valid, output wr_a, output wr_b, input wr_ready);
  modport slave  (input wr_valid, input wr_a, input wr_b, output wr_ready);
endinterface

// File: rtl/pe_operand_fifo.sv
// Circular operand-pair buffer; pointers wrap modulo DEPTH (power of two).
module pe_operand_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pe_feeder.sv
// Buffers operand pairs and streams them into a PE accumulator, returning
// the dot product as the accumulator delta over the run.
module pe_feeder
  import tpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int PE_LAT     = DEF_PE_LAT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pe_feeder_if.slave              wr,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ACC_WIDTH-1:0]    result,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    pe_en,
  output logic [DATA_WIDTH-1:0]   pe_a,
  output logic [DATA_WIDTH-1:0]   pe_b,
  input  logic [ACC_WIDTH-1:0]    pe_c
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int LW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  feeder_state_t           state;
  logic                    push;
  logic                    pop;
  logic [2*DATA_WIDTH-1:0] head;
  logic [CW-1:0]           remaining;
  logic [LW-1:0]           drain_cnt;
  logic [ACC_WIDTH-1:0]    base;

  assign wr.wr_ready = (state == IDLE) && (count < CW'(DEPTH));
  assign push        = wr.wr_valid && wr.wr_ready;
  // First pair is popped on the start edge itself so pe_en rises the next cycle.
  assign pop  = ((state == IDLE) && start && (count != '0)) ||
                ((state == STREAM) && (remaining != '0));
  assign busy = (state != IDLE);

  pe_operand_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data ({wr.wr_a, wr.wr_b}),
    .rd_data (head),
    .count   (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      drain_cnt <= '0;
      base      <= '0;
      result    <= '0;
      done      <= 1'b0;
      pe_en     <= 1'b0;
      pe_a      <= '0;
      pe_b      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              base         <= pe_c;
              remaining    <= count - CW'(1);
              pe_en        <= 1'b1;
              {pe_a, pe_b} <= head;
              state        <= STREAM;
            end else begin
              result <= '0;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        STREAM: begin
          if (remaining != '0) begin
            remaining    <= remaining - CW'(1);
            {pe_a, pe_b} <= head;
          end else begin
            pe_en     <= 1'b0;
            pe_a      <= '0;
            pe_b      <= '0;
            drain_cnt <= LW'(PE_LAT - 1);
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            result <= pe_c - base;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            drain_cnt <= drain_cnt - LW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, operand width.
REQ-002 The module SHALL have parameter ACC_WIDTH, default 16, PE accumulator width.
REQ-003 The module SHALL have parameter DEPTH, default 8 (power of two, at least 2), operand-pair buffer depth.
REQ-004 The module SHALL have parameter PE_LAT, default 1 (at least 1), cycles from last pe_en cycle to final pe_c.
REQ-005 The module SHALL have one clock: clk, input, 1, single clock domain, rising edge.
REQ-006 The module SHALL have one reset: rst_n, input, 1, asynchronous assert, active-low.
REQ-007 The module SHALL have port wr_valid, input, 1: operand pair offered.
REQ-008 The module SHALL have port wr_ready, output, 1: pair accepted when wr_valid and wr_ready are both high at an edge.
REQ-009 The module SHALL have ports wr_a and wr_b, input, DATA_WIDTH each: operand pair.
REQ-010 The module SHALL have port start, input, 1: begin a dot-product run.
REQ-011 The module SHALL have port busy, output, 1: run in progress.
REQ-012 The module SHALL have port done, output, 1: one-cycle pulse marking result valid.
REQ-013 The module SHALL have port result, output, ACC_WIDTH: dot product of the last run.
REQ-014 The module SHALL have port count, output, clog2(DEPTH)+1: buffer fill level.
REQ-015 The module SHALL have ports pe_en, output, 1, and pe_a and pe_b, output, DATA_WIDTH each, which drive PE en, A_in and B_in.
REQ-016 The module SHALL have port pe_c, input, ACC_WIDTH, connected from PE C_out.

Function
REQ-017 FSM states SHALL be IDLE, STREAM, DRAIN and DONE.
REQ-018 wr_ready SHALL equal (state==IDLE && count<DEPTH); a write while full or non-IDLE SHALL be ignored.
REQ-019 In IDLE, start with count=N>0 SHALL capture pe_c into base and go to STREAM.
REQ-020 In IDLE, start with count=0 SHALL go directly to DONE with result 0, and pe_en SHALL never assert.
REQ-021 When start and a write coincide in IDLE, the write SHALL be accepted and SHALL NOT be part of the run; N is the count before that edge.
REQ-022 STREAM SHALL pop one pair per cycle in FIFO order and drive pe_en=1 with pe_a and pe_b registered, for exactly N consecutive cycles, then go to DRAIN.
REQ-023 When pe_en=0, pe_a and pe_b SHALL be 0.
REQ-024 DRAIN SHALL last PE_LAT cycles and then register result = pe_c - base (modulo 2^ACC_WIDTH), so that a non-cleared PE accumulator is tolerated.
REQ-025 DONE SHALL hold done=1 for one cycle and then return to IDLE.
REQ-026 result SHALL hold its value until the next done.
REQ-027 busy SHALL be 1 in STREAM, DRAIN and DONE.
REQ-028 start outside IDLE SHALL be ignored.
REQ-029 Latency SHALL be as follows: for start sampled at edge T0, pe_en is high in cycles T0+1..T0+N, and done is high in cycle T0+N+PE_LAT+1.
REQ-030 The buffer SHALL be circular, with pointers wrapping modulo DEPTH, and SHALL be empty after every run.

Reset
REQ-031 On rst_n low, the module SHALL asynchronously enter IDLE and clear pointers, count, base, result, pe_en, pe_a, pe_b and done to 0; wr_ready SHALL then be 1 and busy 0.
REQ-032 Reset mid-run SHALL abort the run; buffered pairs are discarded and no done is issued.

Structure
REQ-033 The FSM state enumeration and default widths SHALL live in the shared package tpu_pkg.
REQ-034 The operand buffer SHALL be one sub-module, pe_operand_fifo (DEPTH x 2*DATA_WIDTH, with push, pop and count); the FSM and subtraction SHALL reside in pe_feeder.

Verification
REQ-035 The bench SHALL cover this scenario: write (3,4), (2,5), (0,6), (2,8), then start -> pe_en high for 4 cycles, done at T0+6, result=38.
REQ-036 The bench SHALL cover this scenario: after REQ-035 with the PE not reset (pe_c=38), write (1,1), then start -> result=1.
REQ-037 The bench SHALL cover this scenario: write (255,255) twice, then start -> result=64514, confirming modulo wrap.
REQ-038 The bench SHALL cover this scenario: 9 writes with wr_valid held -> wr_ready low after the 8th, count=8, and the 9th pair is not stored.
REQ-039 The bench SHALL cover this scenario: start with an empty buffer -> done next cycle with result=0 and no pe_en pulse.
REQ-040 The bench SHALL cover this scenario: rst_n low during the second STREAM cycle -> pe_en=0 immediately, count=0, no done, and wr_ready=1 after release.
